// File: rtl/ygr_xfer_pkg.sv
// ygr_xfer_pkg: shared types and elaboration helpers for the transfer FIFO.
//   xfer_state_t : DREQ state machine encoding (IDLE, REQ, GAP)
//   level_width  : bit width needed to hold an occupancy of 0..depth
//   cfg_ok       : parameter legality check used at elaboration time
package ygr_xfer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } xfer_state_t;

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit cfg_ok(input int depth, input int burst,
                                  input int dreq_lo, input int gap);
        return (depth >= 4) && ((depth & (depth - 1)) == 0) &&
               (burst >= 1) && (burst <= depth) &&
               (dreq_lo < depth) && (gap >= 1);
    endfunction

endpackage

// File: rtl/ygr_xfer_ram.sv
// ygr_xfer_ram: DEPTH x DW storage, one synchronous write port and one
// asynchronous read port (distributed RAM). Contents are never reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr
module ygr_xfer_ram #(
    parameter int DW    = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem_r [DEPTH];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/ygr_xfer_fifo.sv
// ygr_xfer_fifo: parametrised SH-2 -> A-bus transfer FIFO.
// Writer: CPU strobe or DMA write on a DACK rising edge (sampled on CE).
// Reader: A-bus pop strobe with wait generation while empty.
//   CLK, RST_N       : clock, asynchronous active-low reset
//   CE               : writer-side enable for DACK sampling and the DREQ FSM
//   CLR              : synchronous flush (highest priority)
//   EN               : transfer enable
//   CPU_WR, CPU_D    : CPU write strobe and data
//   DACK, DMA_D      : DMA acknowledge level and data
//   RD_SEL, RD_STB   : A-bus register select and pop strobe
//   RD_Q, RD_WAIT    : show-ahead head entry and A-bus wait
//   DREQ_N           : DMA request, active-low
//   LEVEL/FULL/EMPTY : registered occupancy status
//   OVF, UDF         : sticky overflow / underflow
module ygr_xfer_fifo #(
    parameter int DW      = 16,
    parameter int DEPTH   = 8,
    parameter int DREQ_LO = DEPTH / 2,
    parameter int BURST   = 4,
    parameter int GAP     = 2
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   CE,
    input  logic                   CLR,
    input  logic                   EN,
    input  logic                   CPU_WR,
    input  logic [DW-1:0]          CPU_D,
    input  logic                   DACK,
    input  logic [DW-1:0]          DMA_D,
    input  logic                   RD_SEL,
    input  logic                   RD_STB,
    output logic [DW-1:0]          RD_Q,
    output logic                   RD_WAIT,
    output logic                   DREQ_N,
    output logic [$clog2(DEPTH):0] LEVEL,
    output logic                   FULL,
    output logic                   EMPTY,
    output logic                   OVF,
    output logic                   UDF
);

    import ygr_xfer_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);
    localparam int BW = $clog2(BURST + 1);
    localparam int GW = $clog2(GAP + 1);

    localparam logic [LW-1:0] DEPTH_V   = LW'(DEPTH);
    localparam logic [LW-1:0] DREQ_LO_V = LW'(DREQ_LO);
    localparam logic [BW-1:0] BURST_V   = BW'(BURST);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);

    if (!cfg_ok(DEPTH, BURST, DREQ_LO, GAP)) begin : g_bad_cfg
        $error("ygr_xfer_fifo: illegal DEPTH/BURST/DREQ_LO/GAP combination");
    end

    logic [AW-1:0]  wr_ptr_r, rd_ptr_r;
    logic [LW-1:0]  level_r;
    logic           full_r, empty_r, ovf_r, udf_r;
    logic           dack_old_r, dreq_n_r;
    xfer_state_t    state_r;
    logic [BW-1:0]  bcnt_r;
    logic [GW-1:0]  gcnt_r;

    logic           dma_edge_s, wa_s, coll_s, pop_s, wr_ok_s, dma_acc_s;
    logic           ram_we_s;
    logic [DW-1:0]  wr_data_s, rd_data_s;
    logic [LW-1:0]  level_nxt_s;
    logic [BW-1:0]  bcnt_inc_s;

    // Write/pop qualification and next occupancy
    always_comb begin
        dma_edge_s = CE & DACK & ~dack_old_r;
        wa_s       = EN & (CPU_WR | dma_edge_s);
        coll_s     = EN & CPU_WR & dma_edge_s;
        pop_s      = RD_STB & ~empty_r;
        // A full FIFO still accepts a write when the same cycle frees a slot
        wr_ok_s    = wa_s & (~full_r | pop_s);
        // CPU wins a collision, so only a write without CPU_WR is a DMA word
        dma_acc_s  = wr_ok_s & ~CPU_WR;
        ram_we_s   = wr_ok_s & ~CLR;
        bcnt_inc_s = bcnt_r + {{(BW-1){1'b0}}, 1'b1};
        if (CPU_WR) begin
            wr_data_s = CPU_D;
        end else begin
            wr_data_s = DMA_D;
        end
        level_nxt_s = level_r;
        if (wr_ok_s && !pop_s) begin
            level_nxt_s = level_r + {{(LW-1){1'b0}}, 1'b1};
        end else if (pop_s && !wr_ok_s) begin
            level_nxt_s = level_r - {{(LW-1){1'b0}}, 1'b1};
        end else begin
            level_nxt_s = level_r;
        end
    end

    // DACK history for rising-edge detection, advanced only on CE
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dack_old_r <= 1'b0;
        end else if (CE) begin
            dack_old_r <= DACK;
        end
    end

    // Pointers, occupancy and sticky error flags
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            ovf_r    <= 1'b0;
            udf_r    <= 1'b0;
        end else if (CLR) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            ovf_r    <= 1'b0;
            udf_r    <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            level_r <= level_nxt_s;
            full_r  <= (level_nxt_s == DEPTH_V);
            empty_r <= (level_nxt_s == {LW{1'b0}});
            if ((wa_s && full_r && !pop_s) || coll_s) begin
                ovf_r <= 1'b1;
            end
            if (RD_STB && empty_r) begin
                udf_r <= 1'b1;
            end
        end
    end

    // DREQ state machine: CLR and EN act every clock, the rest only on CE
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r  <= ygr_xfer_pkg::IDLE;
            dreq_n_r <= 1'b1;
            bcnt_r   <= {BW{1'b0}};
            gcnt_r   <= {GW{1'b0}};
        end else if (CLR || !EN) begin
            state_r  <= ygr_xfer_pkg::IDLE;
            dreq_n_r <= 1'b1;
        end else if (CE) begin
            case (state_r)
                ygr_xfer_pkg::IDLE: begin
                    if (level_r <= DREQ_LO_V) begin
                        state_r  <= ygr_xfer_pkg::REQ;
                        bcnt_r   <= {BW{1'b0}};
                        dreq_n_r <= 1'b0;
                    end
                end
                ygr_xfer_pkg::REQ: begin
                    if ((dma_acc_s && (bcnt_inc_s == BURST_V)) || full_r) begin
                        state_r  <= ygr_xfer_pkg::GAP;
                        gcnt_r   <= {GW{1'b0}};
                        dreq_n_r <= 1'b1;
                    end else if (dma_acc_s) begin
                        bcnt_r <= bcnt_inc_s;
                    end
                end
                ygr_xfer_pkg::GAP: begin
                    if (gcnt_r == GAP_LAST) begin
                        state_r <= ygr_xfer_pkg::IDLE;
                    end else begin
                        gcnt_r <= gcnt_r + {{(GW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r  <= ygr_xfer_pkg::IDLE;
                    dreq_n_r <= 1'b1;
                end
            endcase
        end
    end

    ygr_xfer_ram #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (CLK),
        .we    (ram_we_s),
        .waddr (wr_ptr_r),
        .wdata (wr_data_s),
        .raddr (rd_ptr_r),
        .rdata (rd_data_s)
    );

    // Head is masked while empty so stale storage never reaches the bus
    assign RD_Q    = empty_r ? {DW{1'b0}} : rd_data_s;
    assign RD_WAIT = RD_SEL & empty_r;
    assign DREQ_N  = dreq_n_r;
    assign LEVEL   = level_r;
    assign FULL    = full_r;
    assign EMPTY   = empty_r;
    assign OVF     = ovf_r;
    assign UDF     = udf_r;

endmodule

// File: tb/tb_ygr_xfer_fifo.sv
// tb_ygr_xfer_fifo: directed scenarios plus a randomized run checked against
// a queue-based reference model of the FIFO.
module tb_ygr_xfer_fifo;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n, ce, clr, en, cpu_wr, dack, rd_sel, rd_stb;
    logic [15:0] cpu_d, dma_d, rd_q;
    logic        rd_wait, dreq_n, full, empty, ovf, udf;
    logic [3:0]  level;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [15:0] mq[$];
    bit          m_ovf, m_udf, m_old;

    ygr_xfer_fifo dut (
        .CLK(clk), .RST_N(rst_n), .CE(ce), .CLR(clr), .EN(en),
        .CPU_WR(cpu_wr), .CPU_D(cpu_d), .DACK(dack), .DMA_D(dma_d),
        .RD_SEL(rd_sel), .RD_STB(rd_stb), .RD_Q(rd_q), .RD_WAIT(rd_wait),
        .DREQ_N(dreq_n), .LEVEL(level), .FULL(full), .EMPTY(empty),
        .OVF(ovf), .UDF(udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic dma_wr(input logic [15:0] d);
        dack = 1'b1; dma_d = d; tick;
        dack = 1'b0; tick;
    endtask

    task automatic cpu_write(input logic [15:0] d);
        cpu_wr = 1'b1; cpu_d = d; tick;
        cpu_wr = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step;
        bit edge_s, wa, pop;
        edge_s = ce && dack && !m_old;
        if (clr) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            wa  = en && (cpu_wr || edge_s);
            pop = rd_stb && (mq.size() > 0);
            if (rd_stb && mq.size() == 0) m_udf = 1'b1;
            if (en && cpu_wr && edge_s) m_ovf = 1'b1;
            if (wa && mq.size() == DEPTH && !pop) begin
                m_ovf = 1'b1;
                wa = 1'b0;
            end
            if (pop) void'(mq.pop_front());
            if (wa) mq.push_back(cpu_wr ? cpu_d : dma_d);
        end
        if (ce) m_old = dack;
    endtask

    initial begin
        bit ok;
        logic [15:0] expq[$];
        logic [15:0] w;
        bit force_off;

        rst_n = 1'b0; ce = 1'b1; clr = 1'b0; en = 1'b1; cpu_wr = 1'b0;
        cpu_d = 16'h0; dack = 1'b0; dma_d = 16'h0; rd_sel = 1'b0; rd_stb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_udf", udf, 0);
        chk("rst_dreq", dreq_n, 1);
        chk("rst_rdq", rd_q, 0);
        rst_n = 1'b1;
        tick;
        chk("dreq_after_rst", dreq_n, 0);

        // Test 1: one burst of four DMA writes, then the deassert gap
        for (int i = 0; i < 4; i++) begin
            dack = 1'b1; dma_d = 16'h1111 * (i + 1); tick;
            if (i < 3) begin
                dack = 1'b0; tick;
                chk("dreq_in_burst", dreq_n, 0);
            end
        end
        chk("gap_start", dreq_n, 1);
        chk("lvl4", level, 4);
        dack = 1'b0; tick;
        chk("gap_hold", dreq_n, 1);
        ok = 1'b0;
        for (int i = 0; i < 4 && !ok; i++) begin
            tick;
            if (dreq_n == 1'b0) ok = 1'b1;
        end
        chk("rereq", ok, 1);

        // Test 2: fill to full, no re-request, overflow on a 9th word
        for (int i = 4; i < 8; i++) dma_wr(16'h1111 * (i + 1));
        chk("lvl8", level, 8);
        chk("full8", full, 1);
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (dreq_n != 1'b1) ok = 1'b0;
        end
        chk("no_rereq_full", ok, 1);
        dma_wr(16'h9999);
        chk("ovf9", ovf, 1);
        chk("lvl_ovf", level, 8);
        chk("head_ovf", rd_q, 16'h1111);

        // Test 4: pop plus DACK edge while full, then ordered wrap traffic
        clr = 1'b1; tick; clr = 1'b0;
        chk("clr_ovf", ovf, 0);
        for (int i = 0; i < 8; i++) cpu_write(16'hA000 + 16'(i));
        chk("cpu_full", full, 1);
        rd_stb = 1'b1; dack = 1'b1; dma_d = 16'hD00D; tick;
        rd_stb = 1'b0; dack = 1'b0; tick;
        chk("fullpop_lvl", level, 8);
        chk("fullpop_ovf", ovf, 0);
        chk("fullpop_head", rd_q, 16'hA001);
        expq = {16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005, 16'hA006, 16'hA007, 16'hD00D};
        for (int r = 0; r < 4; r++) begin
            if (r > 0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    w = 16'($urandom);
                    expq.push_back(w);
                    cpu_write(w);
                end
            end
            while (expq.size() > 0) begin
                w = expq.pop_front();
                chk("wrap_data", rd_q, w);
                rd_stb = 1'b1; tick; rd_stb = 1'b0;
            end
        end
        chk("drained", empty, 1);

        // Test 3: A-bus wait around a single CPU word
        rd_sel = 1'b1; #1;
        chk("wait_empty", rd_wait, 1);
        cpu_write(16'hBEEF);
        chk("beef_empty", empty, 0);
        chk("beef_wait", rd_wait, 0);
        chk("beef_q", rd_q, 16'hBEEF);
        rd_stb = 1'b1; tick; rd_stb = 1'b0;
        chk("pop_empty", empty, 1);
        chk("pop_wait", rd_wait, 1);
        rd_sel = 1'b0;

        // Test 5: underflow, collision overflow, then CLR mid-burst
        rd_stb = 1'b1; tick; rd_stb = 1'b0;
        chk("udf_set", udf, 1);
        chk("udf_lvl", level, 0);
        en = 1'b0; tick; en = 1'b1; tick;
        chk("req_again", dreq_n, 0);
        cpu_wr = 1'b1; cpu_d = 16'hC001; dack = 1'b1; dma_d = 16'hDEAD; tick;
        cpu_wr = 1'b0; dack = 1'b0; tick;
        chk("coll_ovf", ovf, 1);
        chk("coll_head", rd_q, 16'hC001);
        dma_wr(16'h0002);
        dma_wr(16'h0003);
        chk("mid_lvl", level, 3);
        chk("mid_dreq", dreq_n, 0);
        clr = 1'b1; tick; clr = 1'b0;
        chk("clr_lvl", level, 0);
        chk("clr_ovf2", ovf, 0);
        chk("clr_udf", udf, 0);
        chk("clr_dreq", dreq_n, 1);
        chk("clr_empty", empty, 1);
        tick;
        chk("clr_rereq", dreq_n, 0);

        // Randomized run against the reference model
        dack = 1'b0; clr = 1'b1; tick; clr = 1'b0;
        mq.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_old = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            ce     = ($urandom % 4) != 0;
            dack   = 1'($urandom % 2);
            cpu_wr = ($urandom % 5) == 0;
            cpu_d  = 16'($urandom);
            dma_d  = 16'($urandom);
            rd_sel = 1'($urandom % 2);
            rd_stb = ((cyc / 60) % 2 == 0) ? (($urandom % 5) == 0) : (($urandom % 5) < 3);
            en     = ($urandom % 16) != 0;
            clr    = ($urandom % 97) == 0;
            force_off = clr || !en;
            model_step();
            tick;
            chk("r_level", level, mq.size());
            chk("r_full", full, mq.size() == DEPTH);
            chk("r_empty", empty, mq.size() == 0);
            chk("r_ovf", ovf, m_ovf);
            chk("r_udf", udf, m_udf);
            chk("r_rdq", rd_q, (mq.size() > 0) ? mq[0] : 16'h0);
            chk("r_wait", rd_wait, rd_sel && (mq.size() == 0));
            if (force_off) chk("r_dreq_off", dreq_n, 1);
        end

        // Test 6: EN dropped in REQ, then asynchronous reset mid-transfer
        ce = 1'b1; dack = 1'b0; cpu_wr = 1'b0; rd_stb = 1'b0; rd_sel = 1'b0; en = 1'b1;
        clr = 1'b1; tick; clr = 1'b0; tick;
        chk("t6_req", dreq_n, 0);
        dma_wr(16'h6001);
        chk("t6_lvl1", level, 1);
        en = 1'b0; tick;
        chk("en_off_dreq", dreq_n, 1);
        dma_wr(16'h6002);
        dma_wr(16'h6003);
        chk("en_off_lvl", level, 1);
        en = 1'b1;
        dack = 1'b1; dma_d = 16'h6004;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_level", level, 0);
        chk("arst_empty", empty, 1);
        chk("arst_full", full, 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_udf", udf, 0);
        chk("arst_dreq", dreq_n, 1);
        chk("arst_rdq", rd_q, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ygr_xfer_fifo.md
Name: ygr_xfer_fifo

Overview:
- Parametrised transfer FIFO for the CD block bridge. It generalises the fixed 8x16 host data FIFO to configurable width, depth, DREQ threshold and burst length.
- Writer side is the SH-2: CPU register write, or DMA write qualified by a DACK rising edge. Reader side is the A-bus, with wait generation while empty.
- Adds occupancy output, sticky overflow/underflow flags, a burst-limited DREQ state machine with a guaranteed deassert gap, and synchronous flush.

Parameters:
DW, 16, data width in bits
DEPTH, 8, entry count; power of two, >=4
AW, $clog2(DEPTH), pointer width (derived; not overridable)
DREQ_LO, DEPTH/2, DREQ may assert only when LEVEL <= DREQ_LO
BURST, 4, accepted DMA writes per DREQ assertion; 1..DEPTH
GAP, 2, minimum CE cycles DREQ_N stays high between bursts; >=1

Ports:
CLK  in  1  system clock
RST_N  in  1  reset, asynchronous, active-low
CE  in  1  writer-side clock enable; DACK sampling, FSM and GAP counting advance only on CE
CLR  in  1  synchronous flush, one-cycle pulse
EN  in  1  transfer enable (TRCTL[2] equivalent)
CPU_WR  in  1  one-cycle CPU write strobe, already edge-qualified
CPU_D  in  DW  CPU write data
DACK  in  1  DMA acknowledge, level
DMA_D  in  DW  DMA write data
RD_SEL  in  1  A-bus data register selected
RD_STB  in  1  one-cycle pop strobe (end of A-bus read)
RD_Q  out  DW  head entry, show-ahead
RD_WAIT  out  1  A-bus wait request
DREQ_N  out  1  DMA request, active-low
LEVEL  out  AW+1  occupancy, 0..DEPTH
FULL  out  1  LEVEL==DEPTH
EMPTY  out  1  LEVEL==0
OVF  out  1  sticky overflow
UDF  out  1  sticky underflow

Behaviour:
- Reset values: pointers=0, LEVEL=0, EMPTY=1, FULL=0, OVF=0, UDF=0, DREQ_N=1, FSM=IDLE, RD_Q=0. Storage contents are not reset.
- Write accept (wa): EN & (CPU_WR | (CE & DACK & ~DACK_old)).
  - DACK_old updates on CE only.
  - If CPU_WR and the DACK edge occur in the same cycle, CPU_D is written and the DMA word is dropped; OVF is set.
- Pop: RD_STB & ~EMPTY. RD_STB while EMPTY is ignored and sets UDF.
- wa while FULL without a same-cycle pop: ignored, sets OVF.
- wa while FULL with a same-cycle pop: both take effect; LEVEL unchanged.
- wa and pop in the same cycle otherwise: both pointers advance; LEVEL unchanged.
- Pointers wrap modulo DEPTH.
- LEVEL, FULL and EMPTY are registered and update in the cycle after the event.
- RD_Q = mem[rd_ptr], combinational read. A write into an empty FIFO is visible on RD_Q one cycle later.
- RD_WAIT = RD_SEL & EMPTY. It deasserts in the cycle EMPTY clears; there is no extra latency.
- CLR has priority over all other events: pointers, LEVEL, OVF and UDF go to 0, EMPTY=1, FSM=IDLE, DREQ_N=1. A same-cycle write or pop is discarded.
- EN=0 forces FSM=IDLE and DREQ_N=1 on the next cycle. Pops are still allowed while EN=0.
- DREQ FSM, evaluated on CE; CLR and EN override it asynchronously to CE:
  - IDLE: if EN & LEVEL<=DREQ_LO, go to REQ with bcnt=0. DREQ_N goes low on the same clock edge that enters REQ.
  - REQ: each accepted DMA write increments bcnt. When the write that makes bcnt reach BURST is accepted, or FULL asserts, go to GAP with gcnt=0 and DREQ_N=1.
  - GAP: gcnt increments each CE. At gcnt==GAP-1, go to IDLE.
- bcnt width is $clog2(BURST+1); gcnt width is $clog2(GAP+1). Neither counter wraps.
- CPU writes affect LEVEL but not bcnt.
- OVF and UDF clear only on CLR or reset.

Decomposition:
- Package ygr_xfer_pkg holds:
  - xfer_state_t enum {IDLE, REQ, GAP}
  - a width-checking function for LEVEL
  - elaboration assertions: DEPTH power of two, 1<=BURST<=DEPTH, DREQ_LO<DEPTH
- Sub-module ygr_xfer_ram: DEPTH x DW storage with one synchronous write port and one asynchronous read port. It maps to distributed RAM.
- The top level holds the pointers, LEVEL, flags and FSM.

Test Plan:
1. Defaults, EN=1, CE every cycle, no DACK → DREQ_N low one cycle after reset release. Then 4 DACK rising edges with data 0x1111..0x4444 → DREQ_N high after the 4th, LEVEL=4, held high for 2 CE cycles, then low again since 4<=DREQ_LO.
2. Continue DMA until LEVEL=8 → FULL=1, FSM goes to GAP, no re-request. A 9th DACK edge → OVF=1, LEVEL stays 8, RD_Q=0x1111.
3. Empty FIFO with RD_SEL=1 → RD_WAIT=1. CPU_WR 0xBEEF → next cycle EMPTY=0, RD_WAIT=0, RD_Q=0xBEEF. RD_STB → EMPTY=1, RD_WAIT=1.
4. FULL FIFO: pop and DACK edge in the same cycle → LEVEL stays 8, OVF stays 0, head advances to the second word. Then fill and drain 3xDEPTH words in order → output sequence matches input exactly across pointer wrap.
5. RD_STB while EMPTY → UDF=1, LEVEL stays 0. Then CLR mid-burst (FSM=REQ, LEVEL=3) → next cycle LEVEL=0, OVF=0, UDF=0, DREQ_N=1, FSM=IDLE; re-request follows on the next CE.
6. EN dropped in REQ → DREQ_N=1 next cycle; DACK edges ignored and LEVEL unchanged. Assert RST_N low asynchronously mid-transfer → all outputs immediately at reset values.
